// File: rtl/dibu_pkg.sv
// Shared definitions for the DIBU control unit.
// Holds the control-word bit indices, opcode encodings, flag bit
// positions and the micro-sequencer state encoding.
package dibu_pkg;

  localparam int SIGNALS_SIZE = 16;

  // Control-word bit indices
  localparam int SIG_IR_W_EN      = 0;
  localparam int SIG_PC_W_EN      = 1;
  localparam int SIG_PC_REF_INC   = 2;
  localparam int SIG_PC_REF_DEC   = 3;
  localparam int SIG_PC_SET       = 4;
  localparam int SIG_MAR_W_EN     = 5;
  localparam int SIG_REG_RW       = 6;
  localparam int SIG_ALU_OUT_EN   = 7;
  localparam int SIG_FLAGS_EN     = 8;
  localparam int SIG_IMM_EN       = 9;
  localparam int SIG_DAR_W_EN     = 10;
  localparam int SIG_MDR_W_EN     = 11;
  localparam int SIG_DMEM_W_EN    = 12;
  localparam int SIG_MDR_OUT_EN   = 13;
  localparam int SIG_REG_TO_MDR   = 14;
  localparam int SIG_FLAGS_W_EN   = 15;

  // Opcode encodings (IR[15:11]); 00xxx is the ALU class
  localparam logic [4:0] OP_MOVI    = 5'b01000;
  localparam logic [4:0] OP_RDF     = 5'b01001;
  localparam logic [4:0] OP_LD_DIR  = 5'b10000;
  localparam logic [4:0] OP_ST_DIR  = 5'b10001;
  localparam logic [4:0] OP_LD_IND  = 5'b10010;
  localparam logic [4:0] OP_ST_IND  = 5'b10011;
  localparam logic [4:0] OP_JMP     = 5'b11000;
  localparam logic [4:0] OP_JZ      = 5'b11001;
  localparam logic [4:0] OP_JNZ     = 5'b11010;
  localparam logic [4:0] OP_JC      = 5'b11011;
  localparam logic [4:0] OP_CALL    = 5'b11100;
  localparam logic [4:0] OP_RET     = 5'b11101;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  // Flag register bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [4:0] {
    ST_F0   = 5'd0,
    ST_F1   = 5'd1,
    ST_F2   = 5'd2,
    ST_DEC  = 5'd3,
    ST_ALU  = 5'd4,
    ST_MOVI = 5'd5,
    ST_RDF  = 5'd6,
    ST_LD0  = 5'd7,
    ST_LD1  = 5'd8,
    ST_LD2  = 5'd9,
    ST_LD3  = 5'd10,
    ST_ST0  = 5'd11,
    ST_ST1  = 5'd12,
    ST_JMP  = 5'd13,
    ST_CALL = 5'd14,
    ST_RET  = 5'd15,
    ST_HALT = 5'd16
  } state_t;

endpackage

// File: rtl/dibu_ucode_rom.sv
// Micro-code ROM: maps the current sequencer state to the 16-bit
// control word. Purely combinational, so the unit's outputs are Moore.
// Ports:
//   state   - current sequencer state
//   signals - control word driven to the datapath
module dibu_ucode_rom
  import dibu_pkg::*;
(
  input  state_t                  state,
  output logic [SIGNALS_SIZE-1:0] signals
);

  always_comb begin
    signals = '0;
    case (state)
      ST_F0:   signals[SIG_MAR_W_EN] = 1'b1;
      ST_F1:   signals[SIG_PC_W_EN]  = 1'b1;
      ST_F2:   signals[SIG_IR_W_EN]  = 1'b1;
      ST_ALU: begin
        signals[SIG_ALU_OUT_EN] = 1'b1;
        signals[SIG_REG_RW]     = 1'b1;
        signals[SIG_FLAGS_W_EN] = 1'b1;
      end
      ST_MOVI: begin
        signals[SIG_IMM_EN] = 1'b1;
        signals[SIG_REG_RW] = 1'b1;
      end
      ST_RDF: begin
        signals[SIG_FLAGS_EN] = 1'b1;
        signals[SIG_REG_RW]   = 1'b1;
      end
      ST_LD0:  signals[SIG_DAR_W_EN] = 1'b1;
      ST_LD2:  signals[SIG_MDR_W_EN] = 1'b1;
      ST_LD3: begin
        signals[SIG_MDR_OUT_EN] = 1'b1;
        signals[SIG_REG_RW]     = 1'b1;
      end
      ST_ST0: begin
        signals[SIG_DAR_W_EN]   = 1'b1;
        signals[SIG_MDR_W_EN]   = 1'b1;
        signals[SIG_REG_TO_MDR] = 1'b1;
      end
      ST_ST1:  signals[SIG_DMEM_W_EN] = 1'b1;
      ST_JMP:  signals[SIG_PC_SET]    = 1'b1;
      ST_CALL: begin
        signals[SIG_PC_REF_INC] = 1'b1;
        signals[SIG_PC_SET]     = 1'b1;
      end
      ST_RET:  signals[SIG_PC_REF_DEC] = 1'b1;
      // DEC, LD1 and HALT drive nothing
      default: signals = '0;
    endcase
  end

endmodule

// File: rtl/dibu_control_unit.sv
// Micro-sequenced control unit of the DIBU 8-bit processor.
// Sequences fetch / decode / execute and drives the datapath control word.
// Ports:
//   clk     - clock (gated by run in the datapath)
//   rst     - asynchronous active-high reset, forces the fetch start state
//   opcode  - IR[15:11]
//   flags   - registered ALU flags (bit0 Z, bit1 C, bit2 N, bit3 V)
//   signals - control word, a pure function of the current state
module dibu_control_unit
  import dibu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              opcode,
  input  logic [7:0]              flags,
  output logic [SIGNALS_SIZE-1:0] signals
);

  state_t state;
  state_t state_next;

  // N and V are carried in the flags word but no branch tests them
  logic unused_flags;
  assign unused_flags = ^{flags[7:4], flags[FLAG_V], flags[FLAG_N]};

  // Unknown or unlisted encodings fall to default and take the NOP path
  // back to fetch, so an X opcode can never reach the control word.
  function automatic state_t decode(input logic [4:0] op, input logic [7:0] fl);
    state_t nxt;
    nxt = ST_F0;
    casez (op)
      5'b00???:  nxt = ST_ALU;
      OP_MOVI:   nxt = ST_MOVI;
      OP_RDF:    nxt = ST_RDF;
      OP_LD_DIR,
      OP_LD_IND: nxt = ST_LD0;
      OP_ST_DIR,
      OP_ST_IND: nxt = ST_ST0;
      OP_JMP:    nxt = ST_JMP;
      OP_JZ:     nxt = fl[FLAG_Z]  ? ST_JMP : ST_F0;
      OP_JNZ:    nxt = !fl[FLAG_Z] ? ST_JMP : ST_F0;
      OP_JC:     nxt = fl[FLAG_C]  ? ST_JMP : ST_F0;
      OP_CALL:   nxt = ST_CALL;
      OP_RET:    nxt = ST_RET;
      OP_HALT:   nxt = ST_HALT;
      default:   nxt = ST_F0;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_next = ST_F0;
    case (state)
      ST_F0:   state_next = ST_F1;
      ST_F1:   state_next = ST_F2;
      ST_F2:   state_next = ST_DEC;
      // Flags are looked at only here; later changes cannot redirect a branch
      ST_DEC:  state_next = decode(opcode, flags);
      ST_LD0:  state_next = ST_LD1;
      ST_LD1:  state_next = ST_LD2;
      ST_LD2:  state_next = ST_LD3;
      ST_ST0:  state_next = ST_ST1;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_F0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_F0;
    else     state <= state_next;
  end

  dibu_ucode_rom u_rom (
    .state   (state),
    .signals (signals)
  );

endmodule

// File: tb/tb_dibu_control_unit.sv
// Self-checking bench for dibu_control_unit: an instruction-level model
// predicts the per-cycle control words, a compare process checks them on
// every falling edge, and literal checks pin reset behaviour and
// instruction lengths.
module tb_dibu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  opcode = 5'b0;
  logic [7:0]  flags = 8'h00;
  logic [15:0] signals;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  dibu_control_unit dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .flags   (flags),
    .signals (signals)
  );

  always #5 clk = ~clk;

  // Compare process: one expected word per cycle while an instruction runs
  always @(negedge clk) begin
    if (!rst && exp_q.size() != 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      total++;
      if (signals !== e) begin
        bad++;
        $display("FAIL cycle_word op=%b flags=%h got=%h want=%h", opcode, flags, signals, e);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Instruction-level model: the words seen from F1 up to and including
  // the next F0 (F0 itself was already observed before the call).
  task automatic model_push(input logic [4:0] op, input logic [7:0] fl, input int halt_cycles);
    bit to_fetch;
    to_fetch = 1;
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    if (op[4:3] == 2'b00) exp_q.push_back(16'h80C0);
    else if (op == 5'b01000) exp_q.push_back(16'h0240);
    else if (op == 5'b01001) exp_q.push_back(16'h0140);
    else if (op == 5'b10000 || op == 5'b10010) begin
      exp_q.push_back(16'h0400); exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0800); exp_q.push_back(16'h2040);
    end
    else if (op == 5'b10001 || op == 5'b10011) begin
      exp_q.push_back(16'h4C00); exp_q.push_back(16'h1000);
    end
    else if (op == 5'b11000) exp_q.push_back(16'h0010);
    else if (op == 5'b11001) begin if (fl[0])  exp_q.push_back(16'h0010); end
    else if (op == 5'b11010) begin if (!fl[0]) exp_q.push_back(16'h0010); end
    else if (op == 5'b11011) begin if (fl[1])  exp_q.push_back(16'h0010); end
    else if (op == 5'b11100) exp_q.push_back(16'h0014);
    else if (op == 5'b11101) exp_q.push_back(16'h0008);
    else if (op == 5'b11111) begin
      for (int i = 0; i < halt_cycles; i++) exp_q.push_back(16'h0000);
      to_fetch = 0;
    end
    if (to_fetch) exp_q.push_back(16'h0020);
  endtask

  // Wait (bounded) until the compare process has consumed the queue.
  // Returns at negedge+1 of the last expected cycle.
  task automatic drain(output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 60) begin
      @(negedge clk); #1;
      cycles++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout op=%b left=%0d", opcode, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at negedge+1 while the DUT sits in F0.
  task automatic run(input logic [4:0] op, input logic [7:0] fl, input int want_len);
    int n;
    opcode = op;
    flags  = fl;
    model_push(op, fl, 20);
    drain(n);
    if (want_len > 0) begin
      total++;
      if (n != want_len) begin
        bad++;
        $display("FAIL length op=%b got=%0d want=%0d", op, n, want_len);
      end
    end
  endtask

  // Pulse reset from negedge+1 and come back at negedge+1 in F0.
  task automatic reset_pulse(input string name);
    rst = 1'b1;
    #1 check({name, "_async"}, signals, 16'h0020);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check({name, "_f0"}, signals, 16'h0020);
  endtask

  initial begin
    int n;
    #1 check("reset_state", signals, 16'h0020);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    check("release_f0", signals, 16'h0020);

    run(5'b01010, 8'h00, 4);   // NOP: 0002,0001,0000 then F0
    run(5'b00000, 8'h00, 5);   // ADD
    run(5'b00111, 8'h00, 5);   // ALU op 7
    run(5'b01000, 8'h00, 5);   // MOVI
    run(5'b01001, 8'h00, 5);   // RDF
    run(5'b10000, 8'h00, 8);   // LD direct
    run(5'b10010, 8'h00, 8);   // LD indirect
    run(5'b10001, 8'h00, 6);   // ST direct
    run(5'b10011, 8'h00, 6);   // ST indirect
    run(5'b11000, 8'h00, 5);   // JMP
    run(5'b11001, 8'h01, 5);   // JZ taken
    run(5'b11001, 8'h00, 4);   // JZ not taken
    run(5'b11001, 8'hFE, 4);   // JZ, all but Z set
    run(5'b11010, 8'h00, 5);   // JNZ taken
    run(5'b11010, 8'h01, 4);   // JNZ not taken
    run(5'b11011, 8'h02, 5);   // JC taken
    run(5'b11011, 8'hFD, 4);   // JC not taken
    run(5'b11100, 8'h00, 5);   // CALL
    run(5'b11101, 8'h00, 5);   // RET
    run(5'b11110, 8'h00, 4);   // unlisted -> NOP
    run(5'b10100, 8'h00, 4);   // unlisted -> NOP

    // HALT holds 0x0000, then a reset pulse restarts fetch
    run(5'b11111, 8'h00, 0);
    repeat (3) @(negedge clk);
    #1 check("halt_hold", signals, 16'h0000);
    reset_pulse("halt_rst");
    run(5'b00000, 8'h00, 5);

    // Reset during LD2 aborts the load
    opcode = 5'b10000;
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0800);
    drain(n);
    check("in_ld2", signals, 16'h0800);
    reset_pulse("ld2_rst");
    run(5'b01000, 8'h00, 5);   // clean MOVI after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
